// File: rtl/rob_flush_sequencer_if.sv
// Flush/return/dispatch signal bundle for rob_flush_sequencer.
// master: ROB/freelist/dispatch side. slave: the sequencer.
interface rob_flush_sequencer_if #(
  parameter int N_ROB    = 32,
  parameter int N_WAY    = 2,
  parameter int CDB_BITS = 6
);
  localparam int PEND_W = $clog2(N_ROB) + 1;

  logic                               branch_haz;
  logic [N_ROB-1:0][CDB_BITS-1:0]     free_list_haz;
  logic                               fl_ready;
  logic [N_WAY-1:0]                   ret_valid;
  logic [N_WAY-1:0][CDB_BITS-1:0]     ret_tag;
  logic                               dispatch_stall;
  logic                               busy;
  logic [PEND_W-1:0]                  pending;
  logic                               overflow_err;

  modport master (
    output branch_haz, free_list_haz, fl_ready,
    input  ret_valid, ret_tag, dispatch_stall, busy, pending, overflow_err
  );

  modport slave (
    input  branch_haz, free_list_haz, fl_ready,
    output ret_valid, ret_tag, dispatch_stall, busy, pending, overflow_err
  );
endinterface

// File: rtl/rob_flush_sequencer.sv
// rob_flush_sequencer: captures the squashed destination tags presented on a
// branch flush and returns them to the freelist N_WAY per cycle, holding
// dispatch stalled until recovery finishes.
// Optional build macro: ROB_FLUSH_BYPASS_EN -- in the flush cycle itself the
// lowest N_WAY non-zero tags go straight to the freelist and only the
// remainder is captured.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no recovery in progress; waiting for branch_haz
// S_DRAIN  | captured tags being returned, lowest index first
// S_SETTLE | one cycle for the freelist head to update, then S_IDLE
module rob_flush_sequencer #(
  parameter int N_ROB    = 32,
  parameter int N_WAY    = 2,
  parameter int CDB_BITS = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  rob_flush_sequencer_if.slave bus
);
  localparam int PEND_W = $clog2(N_ROB) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  logic [1:0]                     state;
  logic [N_ROB-1:0][CDB_BITS-1:0] tag_q;
  logic [N_ROB-1:0]               vld_q;
  logic                           ovf_q;

  logic [N_ROB-1:0]               in_nz;
  logic [N_ROB-1:0]               src_vld;
  logic [N_ROB-1:0][CDB_BITS-1:0] src_tag;
  logic [N_ROB-1:0]               rem;
  logic [N_ROB-1:0]               take;
  logic [N_ROB-1:0]               keep;
  logic [N_WAY-1:0]               rv;
  logic [N_WAY-1:0][CDB_BITS-1:0] rt;
  logic [PEND_W-1:0]              pop;
  logic                           found;

  // Tag 0 means "no register", so only non-zero incoming tags are live.
  always_comb begin
    for (int i = 0; i < N_ROB; i++) in_nz[i] = |bus.free_list_haz[i];
  end

  // Choose what may be offered this cycle; nothing is offered while reset is low.
  always_comb begin
    src_vld = '0;
    src_tag = tag_q;
    if (reset) begin
      if (state == S_DRAIN && bus.fl_ready) begin
        src_vld = vld_q;
      end
`ifdef ROB_FLUSH_BYPASS_EN
      else if (state == S_IDLE && bus.branch_haz && bus.fl_ready) begin
        src_vld = in_nz;
        src_tag = bus.free_list_haz;
      end
`endif
    end
  end

  // Pack the lowest-indexed live entries onto the slots, slot 0 first.
  always_comb begin
    rem   = src_vld;
    take  = '0;
    rv    = '0;
    rt    = '0;
    found = 1'b0;
    for (int s = 0; s < N_WAY; s++) begin
      found = 1'b0;
      for (int i = 0; i < N_ROB; i++) begin
        if (!found && rem[i]) begin
          found  = 1'b1;
          rv[s]  = 1'b1;
          rt[s]  = src_tag[i];
          rem[i] = 1'b0;
          take[i] = 1'b1;
        end
      end
    end
    keep = ((state == S_IDLE) ? in_nz : vld_q) & ~take;
  end

  // Count of captured tags still owed to the freelist.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_ROB; i++) pop = pop + PEND_W'(vld_q[i]);
  end

  // Recovery FSM, capture buffer and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
      tag_q <= '0;
      vld_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.branch_haz) begin
            tag_q <= bus.free_list_haz;
            vld_q <= keep;
            state <= (|keep) ? S_DRAIN : S_SETTLE;
          end
        end
        S_DRAIN: begin
          if (bus.branch_haz) ovf_q <= 1'b1;
          vld_q <= keep;
          if (!(|keep)) state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (bus.branch_haz) ovf_q <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ret_valid      = rv;
  assign bus.ret_tag        = rt;
  assign bus.busy           = (state != S_IDLE);
  assign bus.dispatch_stall = (state != S_IDLE) | bus.branch_haz;
  assign bus.pending        = pop;
  assign bus.overflow_err   = ovf_q;
endmodule

// File: doc/rob_flush_sequencer.md
# rob_flush_sequencer

Sequences physical-register recovery after a taken-branch flush of the reorder buffer. When the ROB raises `branch_haz`, it presents every squashed destination tag at once on `free_list_haz`, but the freelist can only accept `N_WAY` tags per cycle. This block captures the flushed tags and returns them to the freelist at `N_WAY` per cycle. It holds dispatch stalled until recovery completes. It sits between the ROB flush outputs, the freelist return port and the dispatch stage.

## Interface
- `N_ROB`, default 32: ROB entries, which equals the width of the flush vector.
- `N_WAY`, default 2: superscalar width, which equals the number of freelist return slots per cycle.
- `CDB_BITS`, default 6: physical-register tag width. Tag 0 means "no register".

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-low. Reset takes effect at a rising edge while `reset`=0.
- `branch_haz`  in  1: ROB flush pulse.
- `free_list_haz`  in  `N_ROB`×`CDB_BITS`: squashed tags, valid only in a cycle with `branch_haz`=1.
- `fl_ready`  in  1: freelist accepts the return slots this cycle.
- `ret_valid`  out  `N_WAY`: per-slot return valid.
- `ret_tag`  out  `N_WAY`×`CDB_BITS`: returned tags.
- `dispatch_stall`  out  1: blocks dispatch.
- `busy`  out  1: state ≠ IDLE.
- `pending`  out  $clog2(`N_ROB`)+1: number of captured tags not yet returned.
- `overflow_err`  out  1: sticky; a flush arrived while busy.

## Operation
- Storage is a buffer of `N_ROB` tags plus a valid bit per entry.
- The FSM has three states: IDLE, DRAIN, SETTLE.
- IDLE:
  - On `branch_haz`=1, load all `N_ROB` tags. Set valid[i] = (tag[i] ≠ 0).
  - If at least one tag is valid, go to DRAIN. Otherwise go to SETTLE.
- DRAIN:
  - When `fl_ready`=1, drive the lowest-indexed valid entries onto the slots in ascending order: slot 0 gets the lowest index. At most `N_WAY` entries are driven.
  - Unused slots have `ret_valid`=0 and `ret_tag`=0.
  - Entries driven this cycle are cleared at the clock edge.
  - When the last valid entries are driven, go to SETTLE.
  - When `fl_ready`=0, all slots are 0 and nothing changes.
- SETTLE: lasts exactly one cycle, giving the freelist time to update its head, then go to IDLE.
- `dispatch_stall` = (state ≠ IDLE) | `branch_haz`. The `branch_haz` term is combinational, so dispatch is blocked in the flush cycle itself.
- `busy` = (state ≠ IDLE).
- `pending` = popcount of the valid bits.
- Duplicate non-zero tags are each returned as-is; there is no de-duplication.
- `branch_haz` while busy: the incoming vector is ignored, the drain continues unchanged, and `overflow_err` is set to 1 until reset.
- Reset values:
  - State is IDLE and all valid bits are 0.
  - `ret_valid`=0, `ret_tag`=0, `pending`=0, `busy`=0, `overflow_err`=0.
  - `dispatch_stall` follows `branch_haz`.
- Reset in the middle of a drain discards all pending tags. No partial return is made after reset.

## Timing
- Capture happens at the edge ending the flush cycle t. The first return is offered in cycle t+1.
- With K valid tags and `fl_ready` held at 1:
  - DRAIN lasts ceil(K/`N_WAY`) cycles.
  - SETTLE is 1 cycle.
  - `dispatch_stall` is high from cycle t through cycle t+ceil(K/`N_WAY`)+1.
  - Dispatch resumes at t+ceil(K/`N_WAY`)+2.
- With K=0, the stall covers cycles t and t+1 only.
- `ret_valid` and `ret_tag` are combinational from the buffer state and `fl_ready`. A transfer completes in the same cycle it is offered.
- Each cycle with `fl_ready`=0 extends DRAIN by one cycle.

## Configuration
- `ROB_FLUSH_BYPASS_EN` defined:
  - In the IDLE flush cycle, if `fl_ready`=1, the lowest `N_WAY` non-zero tags of `free_list_haz` are driven combinationally on `ret_valid`/`ret_tag`.
  - Only the remainder is captured. If the remainder is empty, go directly to SETTLE.
  - This saves one cycle when K ≤ `N_WAY`.
- Not defined: `ret_valid` is 0 in IDLE; behaviour is as described above.

## Test plan
Overrides for all scenarios: `N_ROB`=8, `N_WAY`=2, `CDB_BITS`=6.
- Reset test: hold `reset`=0 for 2 cycles with random inputs → `ret_valid`=0, `pending`=0, `busy`=0, `overflow_err`=0.
- Normal drain: flush with tags {5,0,9,12,0,0,33,0}, `fl_ready`=1 →
  - t+1: slots (5,9); t+2: (12,33).
  - t+3: SETTLE.
  - `dispatch_stall` low at t+4; `pending` sequence 4,2,0.
- Backpressure: same flush, `fl_ready`=0 at t+1 and t+2 → (5,9) first offered at t+3; stall released at t+6.
- Empty flush: all tags 0 → no `ret_valid`; stall high at t and t+1 only.
- Overflow: second `branch_haz` at t+1 with tags {7,…} → tag 7 is never returned; `overflow_err`=1 and stays 1 until reset.
- Reset in the middle of a drain: `reset`=0 at t+1 → at t+2 `pending`=0 and IDLE. With `ROB_FLUSH_BYPASS_EN` instead, a flush with tags {3,4,0…} → (3,4) returned in cycle t, and IDLE is reached at t+2.
